// File: rtl/bram_pkg.sv
// Shared constants and types for the two-port BRAM arbiter.
`timescale 1ns/10ps
package bram_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_PORTS  = 2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // With two ports the pointer simply flips to the port that just lost.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction
endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// Two-way round-robin selector: eligible vector plus priority pointer to one-hot grant.
`timescale 1ns/10ps
module rr_arb2
    import bram_pkg::*;
(
    input  logic [NUM_PORTS-1:0] elig_i,
    input  logic                 ptr_i,
    output logic [NUM_PORTS-1:0] grant_o
);
    always_comb begin
        grant_o = '0;
        case (elig_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = '0;
        endcase
    end
endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter onto a single simple-dual-port BRAM; one op issued per cycle at most.
`timescale 1ns/10ps
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0] elig, grant;
    logic                 ptr_q, ptr_d;
    logic                 w_en_q, w_en_d;
    logic                 r_en_q, r_en_d;
    logic [ADDR_W-1:0]    w_addr_q, w_addr_d;
    logic [ADDR_W-1:0]    r_addr_q, r_addr_d;
    logic [DATA_W-1:0]    w_data_q, w_data_d;
    logic                 sel_port;
    op_e                  sel_op;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // A port being issued this cycle is masked so one request is never issued twice.
    assign elig = {req1 & ~gnt_q[1], req0 & ~gnt_q[0]};

    rr_arb2 u_rr_arb2 (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        sel_port  = grant[1];
        sel_op    = op_e'(sel_port ? we1 : we0);
        sel_addr  = sel_port ? addr1 : addr0;
        sel_wdata = sel_port ? wdata1 : wdata0;

        gnt_d    = grant;
        ptr_d    = ptr_q;
        w_en_d   = 1'b0;
        r_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        r_addr_d = r_addr_q;
        // Memory returns data the cycle after the read strobe; tag it with the issuing port.
        rvalid_d = gnt_q & {NUM_PORTS{r_en_q}};

        if (|grant) begin
            ptr_d = other_port(sel_port);
            if (sel_op == OP_WRITE) begin
                w_en_d   = 1'b1;
                w_addr_d = sel_addr;
                w_data_d = sel_wdata;
            end else begin
                r_en_d   = 1'b1;
                r_addr_d = sel_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            ptr_q    <= 1'b0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            r_addr_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            ptr_q    <= ptr_d;
            w_en_q   <= w_en_d;
            r_en_q   <= r_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            r_addr_q <= r_addr_d;
        end
    end

    assign gnt0       = gnt_q[0];
    assign gnt1       = gnt_q[1];
    assign rvalid0    = rvalid_q[0];
    assign rvalid1    = rvalid_q[1];
    assign rdata0     = mem_r_data;
    assign rdata1     = mem_r_data;
    assign mem_w_en   = w_en_q;
    assign mem_r_en   = r_en_q;
    assign mem_w_addr = w_addr_q;
    assign mem_w_data = w_data_q;
    assign mem_r_addr = r_addr_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with an attached behavioural BRAM.
`timescale 1ns/10ps
module tb_bram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_w_en, mem_r_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data;

    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .mem_w_en   (mem_w_en),
        .mem_r_en   (mem_r_en),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    // clock: 83.34 ns period
    initial clk = 1'b0;
    always #41.67 clk = ~clk;

    // attached BRAM: synchronous write, one-cycle read latency
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    // reference model state
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q[$];
    int            exp_port_q[$];
    int            m_ptr, m_gnt, m_rv;
    bit            m_w_en, m_r_en;
    logic [AW-1:0] m_w_addr, m_r_addr;
    logic [DW-1:0] m_w_data, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gnt = -1; m_rv = -1;
        m_w_en = 0; m_r_en = 0;
        m_w_addr = '0; m_r_addr = '0; m_w_data = '0; m_rdata = '0;
        exp_q.delete();
        exp_port_q.delete();
    endtask

    // Applies the arbitration rules to the inputs seen at this rising edge.
    task automatic model_update();
        bit e0, e1;
        int win;
        bit w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!rst_n) return;
        m_rv = -1;
        if (exp_port_q.size() > 0) begin
            m_rv    = exp_port_q.pop_front();
            m_rdata = exp_q.pop_front();
        end
        e0 = req0 && (m_gnt != 0);
        e1 = req1 && (m_gnt != 1);
        win = -1;
        if (e0 && e1) win = m_ptr;
        else if (e0) win = 0;
        else if (e1) win = 1;
        m_gnt = win;
        m_w_en = 0;
        m_r_en = 0;
        if (win >= 0) begin
            m_ptr = 1 - win;
            w = (win == 0) ? we0 : we1;
            a = (win == 0) ? addr0 : addr1;
            d = (win == 0) ? wdata0 : wdata1;
            if (w) begin
                m_w_en = 1; m_w_addr = a; m_w_data = d;
                ref_mem[a] = d;
            end else begin
                m_r_en = 1; m_r_addr = a;
                exp_q.push_back(ref_mem[a]);
                exp_port_q.push_back(win);
            end
        end
    endtask

    task automatic check_all();
        chk("gnt0", gnt0, (m_gnt == 0));
        chk("gnt1", gnt1, (m_gnt == 1));
        chk("mem_w_en", mem_w_en, m_w_en);
        chk("mem_r_en", mem_r_en, m_r_en);
        chk("strobe_excl", (mem_w_en && mem_r_en), 0);
        chk("mem_w_addr", mem_w_addr, m_w_addr);
        chk("mem_w_data", mem_w_data, m_w_data);
        chk("mem_r_addr", mem_r_addr, m_r_addr);
        chk("rvalid0", rvalid0, (m_rv == 0));
        chk("rvalid1", rvalid1, (m_rv == 1));
        if (m_rv == 0) chk("rdata0", rdata0, m_rdata);
        if (m_rv == 1) chk("rdata1", rdata1, m_rdata);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_rvalid0"}, rvalid0, 0);
        chk({tag, "_rvalid1"}, rvalid1, 0);
        chk({tag, "_w_en"}, mem_w_en, 0);
        chk({tag, "_r_en"}, mem_r_en, 0);
        chk({tag, "_w_addr"}, mem_w_addr, 0);
        chk({tag, "_w_data"}, mem_w_data, 0);
        chk({tag, "_r_addr"}, mem_r_addr, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    // Called from a falling edge; returns at a falling edge with reset released.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_vals(tag);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem_r_data = '0;
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        #5;
        rst_n = 1'b0;
        #1;
        check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // port0 write 0x01 <= 0xFF
        req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'hFF;
        step();
        chk("wr_gnt0", gnt0, 1);
        chk("wr_addr", mem_w_addr, 8'h01);
        chk("wr_data", mem_w_data, 8'hFF);
        req0 = 0;
        step();
        chk("wr_single_pulse", gnt0, 0);

        // port1 reads it back
        req1 = 1; we1 = 0; addr1 = 8'h01;
        step();
        chk("rd_gnt1", gnt1, 1);
        req1 = 0;
        step();
        chk("rd_rvalid1", rvalid1, 1);
        chk("rd_rdata1", rdata1, 8'hFF);
        chk("rd_rvalid0", rvalid0, 0);
        step();

        // simultaneous reads right after reset: port0 first
        do_reset("rst2");
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        step();
        chk("both_first_gnt0", gnt0, 1);
        chk("both_first_addr", mem_r_addr, 8'h10);
        req0 = 0;
        step();
        chk("both_second_gnt1", gnt1, 1);
        chk("both_second_addr", mem_r_addr, 8'h20);
        req1 = 0;
        step();
        step();

        // continuous writes from both ports alternate grants
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'($urandom);
        req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("alt_gnt0", gnt0, (i % 2 == 0));
            chk("alt_gnt1", gnt1, (i % 2 == 1));
            if (m_gnt == 0) begin addr0 = 8'($urandom_range(32, 47)); wdata0 = 8'($urandom); end
            if (m_gnt == 1) begin addr1 = 8'($urandom_range(32, 47)); wdata1 = 8'($urandom); end
        end
        idle_inputs();
        step();
        step();

        // randomized traffic with holds, cancellations and back-to-back requests
        for (int i = 0; i < 400; i++) begin
            if (req0 && m_gnt != 0) begin
                if ($urandom_range(0, 15) == 0) req0 = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                req0 = 1; we0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
            end else begin
                req0 = 0;
            end
            if (req1 && m_gnt != 1) begin
                if ($urandom_range(0, 15) == 0) req1 = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                req1 = 1; we1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
            end else begin
                req1 = 0;
            end
            step();
        end
        idle_inputs();
        step();
        step();

        // reset during a port0 read issue: the read must vanish
        req0 = 1; we0 = 0; addr0 = 8'h01;
        step();
        chk("inflight_gnt0", gnt0, 1);
        chk("inflight_r_en", mem_r_en, 1);
        do_reset("rst3");
        chk("inflight_rvalid0_hold", rvalid0, 0);
        step();
        step();
        step();
        req0 = 1; we0 = 0; addr0 = 8'h05;
        req1 = 1; we1 = 0; addr1 = 8'h06;
        step();
        chk("ptr_restart_gnt0", gnt0, 1);
        chk("ptr_restart_gnt1", gnt1, 0);
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
